sm_violation_handler: RTL
=========================

Name: sm_violation_handler

Overview:
- Downstream consumer of the Sancus SPM access-control violation signal (`omsp_spm_control` violation output).
- Turns a raw, possibly multi-cycle combinational violation into a clean, stretched reset request to the PUC logic.
- Logs the faulting context (pc, prev_pc, data address) into a small FIFO readable after the reset.
- Keeps a saturating violation counter.

Parameters:
- RST_CYCLES, 4: cycles reset_out is held high per accepted violation; legal range 1..255.
- HOLDOFF_CYCLES, 8: cycles after reset_out deasserts during which new violations are not accepted; 0 means no holdoff.
- LOG_DEPTH, 4: log FIFO entries; must be a power of 2, at least 2.
- CNT_W, 8: width of viol_count.
- LOCK_THRESH, 16: count value that triggers lockout. Used only with SM_VIOL_LOCKOUT_EN.

Ports:
- mclk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- violation  in  1  SPM violation, level, from spm_control.
- pc  in  16  current instruction pc.
- prev_pc  in  16  previous instruction pc.
- data_addr  in  16  execution-unit memory address bus.
- data_en  in  1  memory access enable.
- reset_out  out  1  PUC reset request.
- log_valid  out  1  log FIFO is non-empty.
- log_pc  out  16  head entry pc.
- log_prev_pc  out  16  head entry prev_pc.
- log_addr  out  16  head entry data_addr.
- log_data  out  1  head entry data_en flag (1 = data access violation, 0 = fetch violation).
- log_pop  in  1  consume the head entry.
- log_overflow  out  1  sticky flag: an entry was dropped because the FIFO was full.
- clr_count  in  1  clears viol_count and log_overflow.
- viol_count  out  CNT_W  saturating count of violations.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State is IDLE; all timers are 0; FIFO is empty.
  - reset_out=0, log_valid=0, log_* outputs=0, log_overflow=0, viol_count=0.
  - violation_q (registered copy of violation) is cleared to 0.
- reset_out must not be fed back to reset_n; the log and counter survive the PUC.
- State machine: IDLE, ASSERT, HOLDOFF.
  - IDLE: violation=1 at a rising edge is an accepted event.
    - Next state ASSERT; reset_out=1 from the following cycle.
    - The timer is loaded with RST_CYCLES-1.
  - ASSERT: reset_out=1 and the timer decrements each cycle. reset_out is high for exactly RST_CYCLES cycles.
    - At timer 0: go to HOLDOFF with the timer loaded to HOLDOFF_CYCLES-1.
    - If HOLDOFF_CYCLES=0, go directly to IDLE.
  - HOLDOFF: reset_out=0 and the timer decrements. At timer 0, go to IDLE.
  - Violations during ASSERT and HOLDOFF never restart the timer and are not logged.
  - Violation still high on the first IDLE cycle: that cycle is a new accepted event (level-sensitive).
- Logging:
  - On an accepted event, {pc, prev_pc, data_addr, data_en} sampled at that edge is pushed.
  - log_* show the head entry (registered storage, combinational read of the head); they are 0 when empty.
  - log_pop with log_valid=1 advances the read pointer. log_pop while empty is ignored.
  - Push when full with no pop: the entry is dropped and log_overflow is set.
  - Push and pop in the same cycle when full: both happen and there is no overflow.
  - Pointers are log2(LOG_DEPTH)+1 bits and wrap modulo 2*LOG_DEPTH. full/empty are derived from the MSB comparison.
- Counting:
  - viol_count increments by 1 on each accepted event.
  - It also increments on each rising edge of violation (violation & ~violation_q) while in ASSERT or HOLDOFF.
  - It saturates at 2^CNT_W-1.
  - clr_count has priority over an increment in the same cycle. It clears log_overflow; overflow-set has lower priority than clr_count.

Optional Feature:
- Macro: SM_VIOL_LOCKOUT_EN.
- When defined:
  - Adds state LOCKED.
  - When viol_count becomes ≥ LOCK_THRESH (checked on the post-update value), the next state is LOCKED from any state.
  - In LOCKED, reset_out=1 permanently and events are neither logged nor counted.
  - clr_count is ignored. Only reset_n exits LOCKED.
- When undefined: there is no LOCKED state, LOCK_THRESH is unused, and the counter only saturates.

Test Plan:
- Single-cycle violation in IDLE, pc=0xA010, prev_pc=0xA00E, data_addr=0x0600, data_en=1 -> reset_out high on cycles 1-4 after the edge, low for the next 8; log holds {A010, A00E, 0600, 1}; viol_count=1.
- violation held high for 20 cycles -> accepted at cycle 0 and again at the first IDLE cycle (cycle 13); 2 log entries; viol_count=2.
- 5 accepted events with no pops -> 4 entries with the first four pcs in order; log_overflow=1; popping 4 times -> log_valid=0; extra pop is ignored.
- FIFO full and an event coincides with log_pop -> oldest entry removed, new entry appended, log_overflow stays 0.
- Preload viol_count=255 (CNT_W=8), then another event -> count stays 255. clr_count coincident with an event -> count=0.
- With SM_VIOL_LOCKOUT_EN: 16th accepted event -> reset_out stays 1 indefinitely and clr_count has no effect. Pulsing reset_n low mid-ASSERT -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/sm_violation_handler.sv
// Sancus SPM violation handler: stretches violations into a PUC reset request,
// logs faulting context in a small FIFO and keeps a saturating violation counter.
// Optional permanent lockout is enabled by defining SM_VIOL_LOCKOUT_EN.
module sm_violation_handler #(
   parameter int RST_CYCLES     = 4,
   parameter int HOLDOFF_CYCLES = 8,
   parameter int LOG_DEPTH      = 4,
   parameter int CNT_W          = 8,
   parameter int LOCK_THRESH    = 16
) (
   input  logic             mclk,
   input  logic             reset_n,
   input  logic             violation,
   input  logic [15:0]      pc,
   input  logic [15:0]      prev_pc,
   input  logic [15:0]      data_addr,
   input  logic             data_en,
   output logic             reset_out,
   output logic             log_valid,
   output logic [15:0]      log_pc,
   output logic [15:0]      log_prev_pc,
   output logic [15:0]      log_addr,
   output logic             log_data,
   input  logic             log_pop,
   output logic             log_overflow,
   input  logic             clr_count,
   output logic [CNT_W-1:0] viol_count
);

   localparam int AW = $clog2(LOG_DEPTH);
   localparam int PW = AW + 1;
   localparam int TW = 16;
   localparam logic [TW-1:0] RST_LOAD = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] HO_LOAD  = (HOLDOFF_CYCLES > 0) ? TW'(HOLDOFF_CYCLES - 1) : '0;

`ifdef SM_VIOL_LOCKOUT_EN
   typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLDOFF, S_LOCKED} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLDOFF} state_t;
   localparam int unused_lock_thresh = LOCK_THRESH;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t            state;
   logic [TW-1:0]     timer;
   logic              violation_q;
   logic              accept;
   logic              busy;
   logic              rise_inc;
   logic              clr_eff;
   logic              lock_hit;
   logic [CNT_W-1:0]  count_nx;

   logic [48:0]       mem [LOG_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              empty;
   logic              full;
   logic              pop;
   logic              do_push;
   logic [48:0]       head;

   assign accept   = (state == S_IDLE) & violation;
   assign busy     = (state == S_ASSERT) | (state == S_HOLDOFF);
   assign rise_inc = busy & violation & ~violation_q;

`ifdef SM_VIOL_LOCKOUT_EN
   assign clr_eff  = clr_count & (state != S_LOCKED);
   assign lock_hit = 32'(count_nx) >= 32'(LOCK_THRESH);
`else
   assign clr_eff  = clr_count;
   assign lock_hit = 1'b0;
`endif

   always_comb begin
      count_nx = viol_count;
      if (clr_eff)
         count_nx = '0;
      else if (accept | rise_inc)
         count_nx = sat_inc(viol_count);
   end

   // Control FSM; reset_out is registered so it rises the cycle after acceptance
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         timer       <= '0;
         reset_out   <= 1'b0;
         violation_q <= 1'b0;
         viol_count  <= '0;
      end else begin
         violation_q <= violation;
         viol_count  <= count_nx;
         case (state)
            S_IDLE: begin
               if (violation) begin
                  state     <= S_ASSERT;
                  timer     <= RST_LOAD;
                  reset_out <= 1'b1;
               end
            end
            S_ASSERT: begin
               if (timer == '0) begin
                  reset_out <= 1'b0;
                  if (HOLDOFF_CYCLES == 0) begin
                     state <= S_IDLE;
                  end else begin
                     state <= S_HOLDOFF;
                     timer <= HO_LOAD;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_HOLDOFF: begin
               if (timer == '0)
                  state <= S_IDLE;
               else
                  timer <= timer - 1'b1;
            end
`ifdef SM_VIOL_LOCKOUT_EN
            S_LOCKED: begin
               reset_out <= 1'b1;
            end
`endif
            default: begin
               state     <= S_IDLE;
               timer     <= '0;
               reset_out <= 1'b0;
            end
         endcase
`ifdef SM_VIOL_LOCKOUT_EN
         if (lock_hit) begin
            state     <= S_LOCKED;
            reset_out <= 1'b1;
         end
`endif
      end
   end

   // Log FIFO: extra pointer bit distinguishes full from empty
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
   assign pop     = log_pop & ~empty;
   assign do_push = accept & (~full | pop);

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         log_overflow <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (clr_eff)
            log_overflow <= 1'b0;
         else if (accept & full & ~pop)
            log_overflow <= 1'b1;
      end
   end

   always_ff @(posedge mclk) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= {pc, prev_pc, data_addr, data_en};
   end

   assign head        = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign log_valid   = ~empty;
   assign log_pc      = head[48:33];
   assign log_prev_pc = head[32:17];
   assign log_addr    = head[16:1];
   assign log_data    = head[0];

endmodule
